// File: rtl/tl_sync_fifo.sv
// tl_sync_fifo: single-clock show-ahead FIFO with full/empty/almost-full status and occupancy count.
// Define TL_SYNC_FIFO_ERR_EN to enable the sticky overflow/underflow error flag on err_o.
module tl_sync_fifo #(
    parameter int DEPTH_LG2    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRESH = 2**DEPTH_LG2 - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  afull_o,
    input  logic                  rden_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic [DEPTH_LG2:0]    cnt_o,
    output logic                  err_o
);
    localparam int PW = DEPTH_LG2 + 1;
    localparam logic [PW-1:0] AFT  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] PONE = PW'(1);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LG2];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign empty_o  = (r_wptr == r_rptr);
    assign full_o   = (r_wptr[DEPTH_LG2] != r_rptr[DEPTH_LG2]) &&
                      (r_wptr[DEPTH_LG2-1:0] == r_rptr[DEPTH_LG2-1:0]);
    assign cnt_o    = r_wptr - r_rptr;
    assign afull_o  = (cnt_o >= AFT);
    assign rdata_o  = r_mem[r_rptr[DEPTH_LG2-1:0]];
    assign w_wr_acc = wren_i && !full_o;
    assign w_rd_acc = rden_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr[DEPTH_LG2-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PONE;
            if (w_rd_acc) r_rptr <= r_rptr + PONE;
        end
    end

`ifdef TL_SYNC_FIFO_ERR_EN
    logic r_err;
    // Sticky until reset; dropped requests still leave the pointers alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else if ((wren_i && full_o) || (rden_i && empty_o)) r_err <= 1'b1;
    end
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_tl_sync_fifo.sv
// tb_tl_sync_fifo: directed bench for tl_sync_fifo with a queue-based reference model
// compared every negedge, plus literal spot checks.
module tb_tl_sync_fifo;
`ifdef TL_SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int CAP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [31:0] wdata = '0;
    logic        full, afull, empty, err;
    logic [31:0] rdata;
    logic [4:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_q[$];
    logic        m_err = 1'b0;

    tl_sync_fifo #(.DEPTH_LG2(4), .DATA_WIDTH(32), .AFULL_THRESH(14)) dut (
        .clk(clk), .rst_n(rst_n), .wren_i(wren), .wdata_i(wdata), .full_o(full),
        .afull_o(afull), .rden_i(rden), .rdata_o(rdata), .empty_o(empty),
        .cnt_o(cnt), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of stored words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            automatic int  sz = m_q.size();
            automatic bit  wa = wren && (sz < CAP);
            automatic bit  ra = rden && (sz > 0);
            if (ERR_EN && ((wren && sz == CAP) || (rden && sz == 0))) m_err = 1'b1;
            if (ra) void'(m_q.pop_front());
            if (wa) m_q.push_back(wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic int sz = m_q.size();
        chk("m_cnt",   32'(cnt),   32'(sz));
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_full",  32'(full),  32'(sz == CAP));
        chk("m_afull", 32'(afull), 32'(sz >= 14));
        chk("m_err",   32'(err),   32'(m_err));
        if (sz > 0) chk("m_rdata", rdata, m_q[0]);
    end

    task automatic op(input logic w, input logic [31:0] d, input logic r);
        wren = w; wdata = d; rden = r;
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cnt"},   32'(cnt),   32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full),  32'd0);
        chk({tag, "_afull"}, 32'(afull), 32'd0);
        chk({tag, "_err"},   32'(err),   32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_idle("rst");
        op(0, 0, 0);
        chk_idle("idle");
        for (int i = 0; i < 16; i++) begin
            op(1, 32'(i), 0);
            if (i == 12) chk("afull_13", 32'(afull), 32'd0);
            if (i == 13) chk("afull_14", 32'(afull), 32'd1);
            if (i == 14) chk("full_15", 32'(full), 32'd0);
        end
        chk("full_16", 32'(full), 32'd1);
        chk("cnt_16", 32'(cnt), 32'd16);
        op(1, 32'h99, 0);
        chk("ovf_cnt", 32'(cnt), 32'd16);
        chk("ovf_head", rdata, 32'h0);
        chk("ovf_err", 32'(err), 32'(ERR_EN));
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", rdata, 32'(i));
            op(0, 0, 1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        op(0, 0, 1);
        chk("udf_cnt", 32'(cnt), 32'd0);
        op(0, 0, 0);
        chk("err_sticky", 32'(err), 32'(ERR_EN));
        op(1, 32'h5, 0);
        #3 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        op(1, 32'hA, 0);
        chk("one_head", rdata, 32'hA);
        op(1, 32'hB, 1);
        chk("simul_cnt", 32'(cnt), 32'd1);
        chk("simul_data", rdata, 32'hB);
        for (int i = 1; i < 16; i++) op(1, 32'h100 + 32'(i), 0);
        op(1, 32'h55, 1);
        chk("full_rw_cnt", 32'(cnt), 32'd15);
        chk("full_rw_head", rdata, 32'h101);
        for (int i = 0; i < 15; i++) begin
            chk("full_rw_drain", rdata, 32'h101 + 32'(i));
            op(0, 0, 1);
        end
        chk("full_rw_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) op(1, 32'(i), 0);
        for (int i = 0; i < 40; i++) begin
            chk("wrap_data", rdata, 32'(i));
            op(1, 32'(i + 3), 1);
            chk("wrap_cnt", 32'(cnt), 32'd3);
        end
        for (int i = 40; i < 43; i++) begin
            chk("wrap_tail", rdata, 32'(i));
            op(0, 0, 1);
        end
        chk("wrap_empty", 32'(empty), 32'd1);
        op(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tl_sync_fifo.md
# tl_sync_fifo

Single-clock, show-ahead (first-word-fall-through) FIFO for transaction-layer buffering. It consumes the gated write/read enables that drive its occupancy count, and provides a storage array, full/empty/almost-full status, and an occupancy count to the surrounding TL datapath. It sits between a TL packet producer (header/payload assembly) and the downstream consumer (arbiter or link-layer packer), absorbing rate mismatch between them.

## Interface
Parameters:
- DEPTH_LG2, default 4: log2 of the number of entries; capacity is 2**DEPTH_LG2.
- DATA_WIDTH, default 32: entry width in bits.
- AFULL_THRESH, default 2**DEPTH_LG2 - 2: afull_o asserts when count >= this value; legal range 1..2**DEPTH_LG2.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- wren_i, input, 1: write request.
- wdata_i, input, DATA_WIDTH: write data, sampled when the write is accepted.
- full_o, output, 1: FIFO holds 2**DEPTH_LG2 entries.
- afull_o, output, 1: count >= AFULL_THRESH.
- rden_i, input, 1: read request; pops the head entry.
- rdata_o, output, DATA_WIDTH: head entry (show-ahead); valid only while empty_o = 0.
- empty_o, output, 1: FIFO holds 0 entries.
- cnt_o, output, DEPTH_LG2+1: current occupancy, 0..2**DEPTH_LG2.
- err_o, output, 1: sticky protocol-error flag (see Configuration).

## Operation
- Storage: 2**DEPTH_LG2 x DATA_WIDTH register array, not reset.
- Pointers: wptr and rptr, DEPTH_LG2+1 bits each. The low DEPTH_LG2 bits index the array; the MSB is the wrap bit. Both increment modulo 2**(DEPTH_LG2+1).
- Accepted write: wr_acc = wren_i & ~full_o. On wr_acc, mem[wptr[low]] <= wdata_i and wptr++.
- Accepted read: rd_acc = rden_i & ~empty_o. On rd_acc, rptr++.
- Requests against the flag are dropped, with no state change:
  - wren_i while full is dropped, even when rden_i is asserted in the same cycle.
  - rden_i while empty is dropped, even when wren_i is asserted in the same cycle.
- Status decode:
  - empty_o = (wptr == rptr).
  - full_o = (MSBs differ) & (low bits equal).
- Count: cnt_o = wptr - rptr, computed (DEPTH_LG2+1)-bit wide. Equivalently, +1 on wr_acc & ~rd_acc, -1 on rd_acc & ~wr_acc, otherwise held.
- Read data: rdata_o = mem[rptr[low]], combinational from the array and rptr.
- Simultaneous wr_acc and rd_acc:
  - Both pointers advance and the count is unchanged.
  - At count 1, the popped entry is the old head, and the new entry becomes visible on rdata_o the next cycle.
- No bypass: a write to an empty FIFO is visible on rdata_o only in the cycle after the write.

## Timing
- Reset (rst_n = 0), asynchronous and immediate:
  - wptr = rptr = 0, so cnt_o = 0, empty_o = 1, full_o = 0, afull_o = 0.
  - err_o = 0.
  - rdata_o is don't-care.
- Reset asserted mid-operation discards all contents immediately; the array contents are retained but unreachable.
- Write-to-read latency: 1 cycle. Data written at edge N is on rdata_o with empty_o = 0 after edge N.
- Flag timing: full_o, empty_o, afull_o and cnt_o are all registered-pointer decodes. They update in the cycle after the accepted operation and are mutually consistent every cycle.
- Upstream must hold wdata_i valid only in the wren_i cycle; no multi-cycle handshake.

## Configuration
- Macro: TL_SYNC_FIFO_ERR_EN.
- Defined:
  - err_o is set on any edge where (wren_i & full_o) or (rden_i & empty_o).
  - err_o stays set until rst_n is asserted.
  - Dropped requests are still dropped, exactly as with the macro undefined.
- Undefined: err_o is tied to 0, and no error logic is synthesized.

## Test plan
- Reset then idle: check cnt_o = 0, empty_o = 1, full_o = 0, afull_o = 0, err_o = 0. Assert rst_n = 0 mid-cycle and check flags return to these values without waiting for a clock edge.
- Fill and drain, DEPTH_LG2 = 4, AFULL_THRESH = 14:
  - Write 16 words 0x0..0xF. Check afull_o rises after the 14th write and full_o after the 16th, with cnt_o = 16.
  - Read 16. Check rdata_o sequence 0x0..0xF and empty_o = 1 after the last read.
- Simultaneous read/write:
  - At cnt_o = 1 (head 0xA), write 0xB with a concurrent read. Check cnt_o stays 1 and rdata_o = 0xB next cycle.
  - At cnt_o = 16, repeat with a concurrent read: the write is dropped and cnt_o = 15.
- Wrap-around: push/pop 40 words through with occupancy held at 3. Check order is preserved across pointer wrap and full_o never asserts.
- Overflow/underflow:
  - Write while full and read while empty. Check pointers and count are unchanged.
  - With TL_SYNC_FIFO_ERR_EN defined, check err_o = 1 and sticky until reset.
  - Without the macro, check err_o = 0.
